matrix_stream_loader: RTL and testbench

- Upstream feeder for the 4x4 Q-format matrix multipliers.
- Accepts a serial stream of N-bit fixed-point words over a valid/ready handshake. Each frame is 2*P*P words: P*P words for A, then P*P words for B.
- Assembles the words into flat P*P*N operand buses A and B. Presents them with m_valid and holds them stable until m_ready.
- Double-buffered: a shadow buffer fills while the previously presented operands are still held.

---
 rtl/matrix_stream_loader_pkg.sv | 21 ++
 rtl/matrix_stream_loader.sv | 115 +++++++++++
 tb/tb_matrix_stream_loader.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/matrix_stream_loader_pkg.sv
// Shared definitions for the matrix operand path: default word format,
// frame length, loader state encoding and the flat-bus element offset.
package matrix_stream_loader_pkg;

  localparam int DEF_N     = 32;
  localparam int DEF_Q     = 18;
  localparam int DEF_P     = 4;
  localparam int FRAME_LEN = 2 * DEF_P * DEF_P;

  typedef enum logic {
    LOAD = 1'b0,
    PEND = 1'b1
  } state_t;

  // Bit offset of element (row, col) in a row-major flat P*P*N bus.
  function automatic int elem_offset(input int row, input int col,
                                     input int p, input int n);
    return (row * p + col) * n;
  endfunction

endpackage

// File: rtl/matrix_stream_loader.sv
// Serial-to-parallel operand loader: collects one A/B frame into a shadow
// buffer and hands it to the output slot with a valid/ready handshake.
module matrix_stream_loader
  import matrix_stream_loader_pkg::*;
#(
  parameter int N           = DEF_N,
  parameter int Q           = DEF_Q,
  parameter int P           = DEF_P,
  parameter int TRANSPOSE_B = 0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [N-1:0]       s_data,
  input  logic               s_valid,
  input  logic               s_first,
  output logic               s_ready,
  output logic [P*P*N-1:0]   A,
  output logic [P*P*N-1:0]   B,
  output logic               m_valid,
  input  logic               m_ready,
  output logic               frame_err
);

  localparam int PP = P * P;
  localparam int FL = 2 * PP;
  localparam int IW = $clog2(FL);

  // Q describes the word format for downstream users only; words pass through untouched.
  if (Q >= N) begin : g_fraction_only_words
  end

  state_t            state, state_nx;
  logic [IW-1:0]     idx, idx_nx, widx;
  logic [PP*N-1:0]   sh_a, sh_b, sh_a_nx, sh_b_nx;
  logic              accept, restart, last, copy;
  int                k, r, c;

  assign s_ready = (state == LOAD);
  assign accept  = s_valid && s_ready;
  assign restart = accept && s_first && (idx != '0);
  assign widx    = restart ? '0 : idx;
  assign last    = accept && (int'(widx) == FL - 1);
  assign copy    = ((state == LOAD) && last && (!m_valid || m_ready)) ||
                   ((state == PEND) && m_ready);

  // Shadow write: the final word is merged here so a same-edge copy sees it.
  always_comb begin
    sh_a_nx = sh_a;
    sh_b_nx = sh_b;
    k = 0;
    r = 0;
    c = 0;
    if (accept) begin
      if (int'(widx) < PP) begin
        sh_a_nx[elem_offset(int'(widx) / P, int'(widx) % P, P, N) +: N] = s_data;
      end else begin
        k = int'(widx) - PP;
        r = k / P;
        c = k % P;
        if (TRANSPOSE_B != 0)
          sh_b_nx[elem_offset(c, r, P, N) +: N] = s_data;
        else
          sh_b_nx[elem_offset(r, c, P, N) +: N] = s_data;
      end
    end
  end

  always_comb begin
    state_nx = state;
    idx_nx   = idx;
    case (state)
      LOAD: begin
        if (accept) begin
          idx_nx = last ? '0 : widx + IW'(1);
          if (last && m_valid && !m_ready)
            state_nx = PEND;
        end
      end
      PEND: begin
        if (m_ready) begin
          state_nx = LOAD;
          idx_nx   = '0;
        end
      end
      default: state_nx = LOAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= LOAD;
      idx       <= '0;
      m_valid   <= 1'b0;
      frame_err <= 1'b0;
      sh_a      <= '0;
      sh_b      <= '0;
      A         <= '0;
      B         <= '0;
    end else begin
      state     <= state_nx;
      idx       <= idx_nx;
      sh_a      <= sh_a_nx;
      sh_b      <= sh_b_nx;
      frame_err <= restart;
      if (copy) begin
        A       <= sh_a_nx;
        B       <= sh_b_nx;
        m_valid <= 1'b1;
      end else if (m_ready) begin
        m_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_matrix_stream_loader.sv
// Directed bench for matrix_stream_loader: a straight-layout instance and a
// transposed-B instance share one input stream.
module tb_matrix_stream_loader;

  localparam int N = 32;
  localparam int P = 4;
  localparam int W = P * P * N;

  logic          clk = 1'b0;
  logic          reset;
  logic [N-1:0]  s_data;
  logic          s_valid;
  logic          s_first;
  logic          m_ready;
  logic          s_ready, s_ready_t;
  logic [W-1:0]  A, B, A_t, B_t;
  logic          m_valid, m_valid_t;
  logic          frame_err, frame_err_t;

  int vectors = 0;
  int errors  = 0;

  always #5 clk = ~clk;

  matrix_stream_loader #(.N(N), .Q(18), .P(P), .TRANSPOSE_B(0)) dut (
    .clk(clk), .reset(reset), .s_data(s_data), .s_valid(s_valid),
    .s_first(s_first), .s_ready(s_ready), .A(A), .B(B),
    .m_valid(m_valid), .m_ready(m_ready), .frame_err(frame_err)
  );

  matrix_stream_loader #(.N(N), .Q(18), .P(P), .TRANSPOSE_B(1)) dut_t (
    .clk(clk), .reset(reset), .s_data(s_data), .s_valid(s_valid),
    .s_first(s_first), .s_ready(s_ready_t), .A(A_t), .B(B_t),
    .m_valid(m_valid_t), .m_ready(m_ready), .frame_err(frame_err_t)
  );

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Present one word for a single cycle; returns 1 time unit after the edge.
  task automatic send_word(input logic [N-1:0] d, input logic first);
    s_data  = d;
    s_first = first;
    s_valid = 1'b1;
    @(posedge clk);
    #1;
    s_valid = 1'b0;
    s_first = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    reset   = 1'b1;
    s_data  = '0;
    s_valid = 1'b0;
    s_first = 1'b0;
    m_ready = 1'b0;
    idle(2);
    reset = 1'b0;

    // Reset state
    check("rst_m_valid", W'(m_valid), W'(0));
    check("rst_s_ready", W'(s_ready), W'(1));
    check("rst_frame_err", W'(frame_err), W'(0));
    check("rst_A", A, '0);
    check("rst_B", B, '0);

    // Basic frame: A = identity at Q18, B = 1..16
    m_ready = 1'b1;
    for (int i = 0; i < 16; i++)
      send_word(((i / 4) == (i % 4)) ? 32'h0004_0000 : 32'h0, i == 0);
    for (int i = 0; i < 15; i++)
      send_word(32'(i + 1), 1'b0);
    check("basic_not_yet_valid", W'(m_valid), W'(0));
    send_word(32'd16, 1'b0);
    check("basic_m_valid", W'(m_valid), W'(1));
    check("basic_A00", W'(A[31:0]), W'(32'h0004_0000));
    check("basic_A01", W'(A[63:32]), W'(0));
    check("basic_A11", W'(A[191:160]), W'(32'h0004_0000));
    check("basic_B00", W'(B[31:0]), W'(1));
    check("basic_B33", W'(B[511:480]), W'(16));
    check("tr_B01", W'(B_t[63:32]), W'(5));
    check("tr_B10", W'(B_t[159:128]), W'(2));
    check("tr_B33", W'(B_t[511:480]), W'(16));
    check("tr_A00", W'(A_t[31:0]), W'(32'h0004_0000));
    idle(1);
    check("basic_valid_drops", W'(m_valid), W'(0));

    // Backpressure: frame 1 fills the slot, frame 2 waits in the shadow
    m_ready = 1'b0;
    for (int i = 0; i < 32; i++)
      send_word(32'(100 + i), i == 0);
    check("bp_f1_valid", W'(m_valid), W'(1));
    check("bp_f1_A00", W'(A[31:0]), W'(100));
    for (int i = 0; i < 32; i++)
      send_word(32'(200 + i), 1'b0);
    check("bp_s_ready_low", W'(s_ready), W'(0));
    check("bp_hold_A00", W'(A[31:0]), W'(100));
    check("bp_hold_B33", W'(B[511:480]), W'(131));
    idle(2);
    check("bp_still_held", W'(A[31:0]), W'(100));
    check("bp_pend_s_ready", W'(s_ready), W'(0));
    m_ready = 1'b1;
    idle(1);
    m_ready = 1'b0;
    check("bp_f2_A00", W'(A[31:0]), W'(200));
    check("bp_f2_B33", W'(B[511:480]), W'(231));
    check("bp_f2_valid", W'(m_valid), W'(1));
    check("bp_s_ready_back", W'(s_ready), W'(1));
    check("bp_tr_B01", W'(B_t[63:32]), W'(220));
    m_ready = 1'b1;
    idle(1);
    check("bp_drained", W'(m_valid), W'(0));

    // Early restart on word 10
    for (int i = 0; i < 9; i++)
      send_word(32'(300 + i), i == 0);
    check("er_no_err_yet", W'(frame_err), W'(0));
    send_word(32'd400, 1'b1);
    check("er_pulse", W'(frame_err), W'(1));
    send_word(32'd401, 1'b0);
    check("er_pulse_once", W'(frame_err), W'(0));
    for (int i = 2; i < 31; i++)
      send_word(32'(400 + i), 1'b0);
    check("er_not_yet_valid", W'(m_valid), W'(0));
    send_word(32'd431, 1'b0);
    check("er_valid", W'(m_valid), W'(1));
    check("er_A00", W'(A[31:0]), W'(400));
    check("er_A01", W'(A[63:32]), W'(401));
    check("er_B33", W'(B[511:480]), W'(431));
    check("er_err_clear", W'(frame_err), W'(0));

    // Simultaneous release: last word and m_ready on the same edge
    m_ready = 1'b0;
    for (int i = 0; i < 31; i++)
      send_word(32'(500 + i), i == 0);
    check("sr_hold_A00", W'(A[31:0]), W'(400));
    m_ready = 1'b1;
    send_word(32'd531, 1'b0);
    m_ready = 1'b0;
    check("sr_A00", W'(A[31:0]), W'(500));
    check("sr_B33", W'(B[511:480]), W'(531));
    check("sr_valid", W'(m_valid), W'(1));
    check("sr_no_pend", W'(s_ready), W'(1));

    // Reset mid-frame
    for (int i = 0; i < 20; i++)
      send_word(32'(600 + i), i == 0);
    reset = 1'b1;
    idle(1);
    reset = 1'b0;
    check("mr_m_valid", W'(m_valid), W'(0));
    check("mr_A", A, '0);
    check("mr_B", B, '0);
    check("mr_s_ready", W'(s_ready), W'(1));
    m_ready = 1'b1;
    for (int i = 0; i < 31; i++)
      send_word(32'(700 + i), i == 0);
    check("mr_not_yet_valid", W'(m_valid), W'(0));
    send_word(32'd731, 1'b0);
    check("mr_valid", W'(m_valid), W'(1));
    check("mr_A00", W'(A[31:0]), W'(700));
    check("mr_A33", W'(A[511:480]), W'(715));
    check("mr_B00", W'(B[31:0]), W'(716));
    check("mr_B33", W'(B[511:480]), W'(731));
    check("mr_no_err", W'(frame_err), W'(0));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
